// File: rtl/mul_div_unit_pkg.sv
// Shared types for the MIPS multiply/divide unit: opcode encoding, widths and
// opcode classification helpers.
package mul_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [OP_W-1:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  function automatic logic is_start_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// E-stage side of the multiply/divide unit: forwarded operands and opcode in,
// start/busy status and mfhi/mflo read data out.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OP_W-1:0]   op;
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] out;

  modport master (output a, b, op, input start, busy, out);
  modport slave  (input a, b, op, output start, busy, out);

endinterface

// File: rtl/mul_div_unit_arith.sv
// Combinational arithmetic core: signed/unsigned 64-bit product and
// quotient/remainder, returned as {hi,lo}; o_valid is low for divide by zero.
module mul_div_unit_arith
  import mul_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  mdu_op_e           i_op,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_valid
);

  logic signed [2*DATA_W-1:0] w_sa;
  logic signed [2*DATA_W-1:0] w_sb;
  logic signed [2*DATA_W-1:0] w_sprod;
  logic        [2*DATA_W-1:0] w_uprod;
  logic                       w_neg_a;
  logic                       w_neg_b;
  logic        [DATA_W-1:0]   w_num;
  logic        [DATA_W-1:0]   w_den;
  logic        [DATA_W-1:0]   w_uq;
  logic        [DATA_W-1:0]   w_ur;

  assign w_sa    = {{DATA_W{i_a[DATA_W-1]}}, i_a};
  assign w_sb    = {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  // Signed divide runs on magnitudes so truncation toward zero falls out naturally.
  assign w_neg_a = (i_op == MDU_DIV) && i_a[DATA_W-1];
  assign w_neg_b = (i_op == MDU_DIV) && i_b[DATA_W-1];
  assign w_num   = w_neg_a ? -i_a : i_a;
  assign w_den   = (i_b == '0) ? DATA_W'(1) : (w_neg_b ? -i_b : i_b);
  assign w_uq    = w_num / w_den;
  assign w_ur    = w_num % w_den;

  always_comb begin
    o_hi    = '0;
    o_lo    = '0;
    o_valid = 1'b1;
    case (i_op)
      MDU_MULT:  {o_hi, o_lo} = w_sprod;
      MDU_MULTU: {o_hi, o_lo} = w_uprod;
      MDU_DIV, MDU_DIVU: begin
        o_lo    = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
        o_hi    = w_neg_a ? -w_ur : w_ur;
        o_valid = (i_b != '0);
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO: computes at accept,
// holds the result pending for a fixed busy window, then commits to HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic              r_pend_ok;
  logic [DATA_W-1:0] w_res_hi, w_res_lo;
  logic              w_res_ok, w_accept, w_commit;
  mdu_op_e           w_op;

  assign w_op = mdu_op_e'(bus.op);

  mul_div_unit_arith u_arith (
    .i_a     (bus.a),
    .i_b     (bus.b),
    .i_op    (w_op),
    .o_hi    (w_res_hi),
    .o_lo    (w_res_lo),
    .o_valid (w_res_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (is_start_op(w_op)) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = is_div_op(w_op) ? DIV_N : MULT_N;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pending result without r_pend_ok (divide by zero) leaves HI/LO untouched at commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_ok <= w_res_ok;
      end
      if (w_commit && r_pend_ok) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else if (r_state == S_IDLE && w_op == MDU_MTHI) begin
        r_hi <= bus.a;
      end else if (r_state == S_IDLE && w_op == MDU_MTLO) begin
        r_lo <= bus.a;
      end
    end
  end

  assign bus.busy  = (r_state == S_RUN);
  assign bus.start = (r_state == S_IDLE) && is_start_op(w_op);
  assign bus.out   = (w_op == MDU_MFHI) ? r_hi :
                     (w_op == MDU_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: scoreboard of expected HI/LO per operation,
// popped and compared once the unit drops busy.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mul_div_unit_if bus ();

  mul_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   busy_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic read_reg(input mdu_op_e op, output logic [31:0] v);
    bus.op = op;
    #1;
    v = bus.out;
    bus.op = MDU_NOP;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] v;
    read_reg(MDU_MFHI, v);
    check({tag, "/hi"}, v, hi);
    read_reg(MDU_MFLO, v);
    check({tag, "/lo"}, v, lo);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.busy === 1'b1) busy_seen++;
  endtask

  // Drive a start-class op for its accept cycle, then scramble the operands.
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    #1;
    check({e.tag, "/start"}, bus.start, 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.op    = MDU_NOP;
    bus.a     = $urandom;
    bus.b     = $urandom;
    busy_seen = (bus.busy === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_done(input int n);
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    e = exp_q.pop_front();
    check({e.tag, "/busy_len"}, busy_seen, n);
    check_hilo(e.tag, e.hi, e.lo);
  endtask

  initial begin
    logic [31:0] v;
    bus.op = MDU_NOP;
    bus.a  = '0;
    bus.b  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst/busy", bus.busy, 0);
    check("rst/start", bus.start, 0);
    check("rst/out_nop", bus.out, 0);
    check_hilo("rst", 32'h0, 32'h0);

    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3, '{"mult", 32'hFFFFFFFF, 32'hFFFFFFFA});
    wait_done(5);

    issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3, '{"multu", 32'h00000002, 32'hFFFFFFFA});
    wait_done(5);

    // Reads and ignored writes while the divide is in flight.
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, '{"div", 32'hFFFFFFFF, 32'hFFFFFFFD});
    check_hilo("div_inflight", 32'h00000002, 32'hFFFFFFFA);
    bus.op = MDU_MTLO;
    bus.a  = 32'hDEADBEEF;
    step();
    bus.op = MDU_NOP;
    check_hilo("div_mtlo_ignored", 32'h00000002, 32'hFFFFFFFA);
    wait_done(10);

    issue(MDU_DIVU, 32'hFFFFFFF9, 32'd2, '{"divu", 32'h00000001, 32'h7FFFFFFC});
    wait_done(10);

    issue(MDU_DIV, 32'd7, 32'hFFFFFFFE, '{"div_negb", 32'h00000001, 32'hFFFFFFFD});
    wait_done(10);

    bus.op = MDU_MTHI;
    bus.a  = 32'h12345678;
    #1;
    check("mthi/start", bus.start, 0);
    step();
    bus.op = MDU_NOP;
    check("mthi/busy", bus.busy, 0);
    read_reg(MDU_MFHI, v);
    check("mthi/hi", v, 32'h12345678);

    issue(MDU_DIV, 32'h00000064, 32'd0, '{"div0", 32'h12345678, 32'hFFFFFFFD});
    bus.op = MDU_MULT;
    bus.a  = 32'd5;
    bus.b  = 32'd5;
    #1;
    check("div0/start_while_busy", bus.start, 0);
    step();
    bus.op = MDU_NOP;
    wait_done(10);

    bus.op = MDU_MTLO;
    bus.a  = 32'hCAFEF00D;
    step();
    bus.op = MDU_NOP;
    check_hilo("mtlo", 32'h12345678, 32'hCAFEF00D);

    issue(MDU_MULT, 32'h80000000, 32'h80000000, '{"mult_min", 32'h40000000, 32'h00000000});
    wait_done(5);
    issue(MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, '{"mult_m1", 32'h00000000, 32'h00000001});
    wait_done(5);
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{"multu_max", 32'hFFFFFFFE, 32'h00000001});
    wait_done(5);

    // Reset in the 3rd busy cycle discards the pending product.
    issue(MDU_MULT, 32'd3, 32'd4, '{"rst_mid", 32'h0, 32'h0});
    step();
    step();
    check("rst_mid/busy_before", busy_seen, 3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid/busy_now", bus.busy, 0);
    check_hilo("rst_mid_now", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    repeat (8) step();
    check("rst_mid/no_busy_after", busy_seen, 0);
    wait_done(0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
